lcd_frame_reader: RTL and testbench
===================================

Name: lcd_frame_reader

Overview:
- Read-side master stage directly upstream of the LCD pixel path.
- Fetches a programmable run of 32-bit words from the on-chip data memory through its single read/write port.
- Memory timing: address registered at the clock edge, readdata valid one cycle later.
- Splits each word into two 16-bit RGB565 pixels and delivers them as a valid/ready stream to the LCD interface; decouples memory latency from LCD backpressure with a small word FIFO.

Parameters:
- ADDR_W, 10, memory word-address width (1024 words).
- FIFO_DEPTH, 4, word FIFO entries; power of two, at least 2.
- CNT_W, 11, width of word_count; allows 0..1024 words.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that launches a transfer; ignored while busy
- base_addr  in  ADDR_W  first word address, sampled on start
- word_count  in  CNT_W  number of words to read, sampled on start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last pixel is accepted
- mem_address  out  ADDR_W  word address to memory
- mem_chipselect  out  1  read-issue strobe; also drives memory clken
- mem_write  out  1  tied 0
- mem_byteenable  out  4  tied 4'b1111
- mem_readdata  in  32  memory read data, valid the cycle after issue
- pix_data  out  16  pixel
- pix_valid  out  1  pixel available
- pix_ready  in  1  sink accepts pixel when valid and ready are both high
- pix_last  out  1  high with the final pixel of a transfer

Behaviour:
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, pix_valid=0, pix_last=0, pix_data=0. FIFO is emptied and all counters are cleared. Reset mid-transfer aborts the transfer; no done pulse.
- Reset has no effect on memory contents.
- FSM states:
  - IDLE: on start with word_count != 0, go to RUN. With word_count == 0, pulse done the next cycle, emit no pixels and stay in IDLE.
  - RUN: issue reads. When all words are issued, go to DRAIN.
  - DRAIN: wait until the last pixel is handshaken, then pulse done and go to IDLE.
- Issue rule: in cycle t, mem_chipselect=1 when words remain to issue AND (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is at most 1.
  - mem_address is incremented after each issue and wraps modulo 2^ADDR_W (1023 -> 0).
- Capture: inflight data from cycle t is written into the FIFO in cycle t+1. The credit rule guarantees the FIFO never overflows; overflow is a design error (assertion).
- Latency with pix_ready held high: start at cycle 0, first issue at cycle 1, FIFO write at cycle 2, pix_valid=1 at cycle 3.
- Steady-state throughput: 1 pixel per cycle (one read every 2 cycles).
- Unpacking:
  - Lower half [15:0] is emitted first, then [31:16].
  - The word is popped from the FIFO on acceptance of the second half.
- Output stream rules:
  - pix_data, pix_valid and pix_last are stable while pix_valid=1 and pix_ready=0 (no retraction).
  - pix_last=1 only on the 2*word_count-th pixel.
- done and start in the same cycle: done is asserted, start is ignored (busy is still high). Start is accepted only in IDLE.
- busy drops in the same cycle done pulses.

Optional Feature:
- Macro: LCD_FRAME_READER_SWAP_HALVES_EN.
- Defined: upper half [31:16] is emitted first, then [15:0] (big-endian pixel packing for firmware that stores pixels that way).
- Undefined: lower half first, as above.
- Timing, handshake and pix_last are identical in both builds.

Decomposition:
- Shared package lcd_pkg holds:
  - ADDR_W and PIX_W = 16 constants
  - state enum {IDLE, RUN, DRAIN}
  - rgb565 struct typedef for pix_data
- Sub-module lcd_word_fifo:
  - synchronous FIFO, FIFO_DEPTH x 32
  - push/pop/count/empty ports
  - first-word-fall-through output
- All credit, FSM and unpack logic stays in the top level.

Test Plan:
- Basic: memory preloaded with word[k] = {16'(2k+1), 16'(2k)}; start base=0, count=4, ready=1. Expect pixels 0..7 in order, pix_last on pixel 7, first pix_valid at cycle 3, done one cycle after the pixel-7 handshake.
- Wrap: base=1022, count=4. Expect mem_address sequence 1022, 1023, 0, 1, and pixels taken from those addresses.
- Backpressure: count=8, pix_ready toggles randomly (50%). Expect no dropped or duplicated pixels, outstanding words never above FIFO_DEPTH, and pix_data held stable during stalls.
- Zero length and busy-start: count=0 gives a done pulse next cycle with no pix_valid; a second start during a transfer is ignored (pixel count still 2x the original count).
- Reset mid-run: assert reset after 3 pixels. Expect all outputs at reset values next cycle, no done pulse, and a following fresh start working normally.
- Swap build (LCD_FRAME_READER_SWAP_HALVES_EN): word 0xBBBB_AAAA emits 0xBBBB then 0xAAAA; the default build emits 0xAAAA then 0xBBBB.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and pixel payload for the LCD frame reader.
// Optional build macro LCD_FRAME_READER_SWAP_HALVES_EN is consumed by lcd_frame_reader.
package lcd_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned PIX_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } rgb565_t;

    // Select one 16-bit pixel out of a packed 32-bit memory word.
    function automatic rgb565_t word_half(input logic [2*PIX_W-1:0] word, input logic upper);
        return upper ? rgb565_t'(word[2*PIX_W-1:PIX_W]) : rgb565_t'(word[PIX_W-1:0]);
    endfunction

endpackage

// File: rtl/lcd_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding fetched memory words.
module lcd_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             empty_q;
    logic             do_pop;

    assign do_pop   = pop && !empty_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = empty_q;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
    end

    // Storage, pointers and occupancy flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    // A push into a full FIFO means the upstream credit accounting is broken.
    always_ff @(posedge clk) begin
        if (!reset && push && !do_pop) begin
            assert (count_q < CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/lcd_frame_reader.sv
// Reads a run of 32-bit words from data memory and streams them as RGB565 pixels.
// Build macro LCD_FRAME_READER_SWAP_HALVES_EN: emit word[31:16] before word[15:0].
module lcd_frame_reader #(
    parameter int unsigned ADDR_W     = lcd_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [CNT_W-1:0]          word_count,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         mem_address,
    output logic                      mem_chipselect,
    output logic                      mem_write,
    output logic [3:0]                mem_byteenable,
    input  logic [31:0]               mem_readdata,
    output logic [lcd_pkg::PIX_W-1:0] pix_data,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic                      pix_last
);

    import lcd_pkg::*;

    localparam int unsigned FC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PC_W = CNT_W + 1;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  issue_left_q;
    logic [CNT_W-1:0]  issue_left_d;
    logic [PC_W-1:0]   pix_left_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cs_q;
    logic              cs_d;
    logic              inflight_q;
    logic              half_q;
    logic              done_q;
    logic              done_d;
    logic              busy_q;

    logic [31:0]       fifo_word;
    logic [FC_W-1:0]   fifo_count;
    logic [FC_W-1:0]   fifo_count_d;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              handshake;
    logic              last_hs;
    logic              start_ok;
    logic              upper_sel;
    rgb565_t           pix_word;

    lcd_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (mem_readdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_word),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign pix_valid = !fifo_empty;
    assign handshake = pix_valid && pix_ready;
    assign fifo_pop  = handshake && half_q;
    assign last_hs   = handshake && (pix_left_q == PC_W'(1));
    assign start_ok  = (state_q == IDLE) && start;

`ifdef LCD_FRAME_READER_SWAP_HALVES_EN
    assign upper_sel = ~half_q;
`else
    assign upper_sel = half_q;
`endif

    assign pix_word       = word_half(fifo_word, upper_sel);
    assign pix_data       = pix_word;
    assign pix_last       = pix_valid && (pix_left_q == PC_W'(1));
    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'b1111;

    // Next state, issue credit and done decision; chipselect is precomputed one cycle ahead.
    always_comb begin
        state_d      = state_q;
        issue_left_d = issue_left_q - CNT_W'(cs_q);
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        state_d      = RUN;
                        issue_left_d = word_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue_left_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        fifo_count_d = fifo_count + FC_W'(inflight_q) - FC_W'(fifo_pop);
        cs_d = (state_d == RUN) && (issue_left_d != '0) &&
               ((fifo_count_d + FC_W'(cs_q)) < FC_W'(FIFO_DEPTH));
    end

    // FSM, read-issue and pixel bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            issue_left_q <= '0;
            pix_left_q   <= '0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            inflight_q   <= 1'b0;
            half_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_left_q <= issue_left_d;
            cs_q         <= cs_d;
            inflight_q   <= cs_q;
            done_q       <= done_d;
            busy_q       <= (state_d != IDLE);
            if (start_ok) begin
                addr_q <= base_addr;
            end else if (cs_q) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (start_ok) begin
                pix_left_q <= {word_count, 1'b0};
                half_q     <= 1'b0;
            end else if (handshake) begin
                pix_left_q <= pix_left_q - PC_W'(1);
                half_q     <= ~half_q;
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Scoreboard bench for lcd_frame_reader with a behavioural memory and pixel model.
module tb_lcd_frame_reader;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 11;
    localparam int unsigned MEM_WORDS  = 1024;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } pix_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_readdata;
    logic [15:0]       pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;

    logic [31:0]       mem_arr [MEM_WORDS];
    pix_t              exp_q[$];
    logic [ADDR_W-1:0] exp_addr[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   issued = 0;
    int   popped_pix = 0;
    logic done_exp = 1'b0;
    logic stall_prev = 1'b0;
    logic [15:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic zero_start = 1'b0;
    logic rand_ready = 1'b0;

    lcd_frame_reader #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_last       (pix_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: address registered at the edge, data valid the next cycle.
    always @(posedge clk) begin
        if (mem_chipselect === 1'b1) mem_readdata <= mem_arr[mem_address];
    end

    // Sink ready: held high or randomised each cycle.
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: words from consecutive wrapped addresses, each split into two pixels.
    task automatic model_push(input int base, input int cnt);
        pix_t p;
        logic [31:0] w;
        int a;
        for (int k = 0; k < cnt; k++) begin
            a = (base + k) % MEM_WORDS;
            w = mem_arr[a];
            exp_addr.push_back(ADDR_W'(a));
`ifdef LCD_FRAME_READER_SWAP_HALVES_EN
            p.data = w[31:16]; p.last = 1'b0; exp_q.push_back(p);
            p.data = w[15:0];  p.last = (k == cnt - 1); exp_q.push_back(p);
`else
            p.data = w[15:0];  p.last = 1'b0; exp_q.push_back(p);
            p.data = w[31:16]; p.last = (k == cnt - 1); exp_q.push_back(p);
`endif
        end
    endtask

    task automatic do_start(input int base, input int cnt, input bit accepted);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = ADDR_W'(base);
        word_count = CNT_W'(cnt);
        zero_start = accepted && (cnt == 0);
        if (accepted) model_push(base, cnt);
        @(posedge clk);
        #1;
        start      = 1'b0;
        zero_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done) break;
        end
        chk("done_seen", 32'(done), 32'(1));
        chk("all_pixels_delivered", 32'(exp_q.size()), 32'(0));
        chk("all_reads_issued", 32'(exp_addr.size()), 32'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_chipselect"}, 32'(mem_chipselect), 32'(0));
        chk({tag, "_address"}, 32'(mem_address), 32'(0));
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'(0));
        chk({tag, "_pix_last"}, 32'(pix_last), 32'(0));
        chk({tag, "_pix_data"}, 32'(pix_data), 32'(0));
    endtask

    // Monitor: scoreboard pops on handshakes; also checks issue order, credit, hold and done.
    always @(negedge clk) begin
        pix_t e;
        logic done_nxt;
        if (reset) begin
            done_exp   = 1'b0;
            stall_prev = 1'b0;
            issued     = 0;
            popped_pix = 0;
        end else begin
            done_nxt = start && zero_start;
            chk("done", 32'(done), 32'(done_exp));
            if (done) chk("busy_low_at_done", 32'(busy), 32'(0));
            if (stall_prev) begin
                chk("hold_valid", 32'(pix_valid), 32'(1));
                chk("hold_data", 32'(pix_data), 32'(prev_data));
                chk("hold_last", 32'(pix_last), 32'(prev_last));
            end
            if (mem_chipselect) begin
                issued++;
                chk("issue_expected", 32'(exp_addr.size() > 0), 32'(1));
                if (exp_addr.size() > 0) chk("mem_address", 32'(mem_address), 32'(exp_addr.pop_front()));
                chk("outstanding_le_depth", 32'((issued - popped_pix / 2) <= int'(FIFO_DEPTH)), 32'(1));
            end
            if (pix_valid && pix_ready) begin
                chk("pixel_expected", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pix_data", 32'(pix_data), 32'(e.data));
                    chk("pix_last", 32'(pix_last), 32'(e.last));
                    if (e.last) done_nxt = 1'b1;
                end
                popped_pix++;
            end
            stall_prev = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_last  = pix_last;
            done_exp   = done_nxt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first_issue;
        int k;
        int p0;
        int b;
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = {16'(2 * i + 1), 16'(2 * i)};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        chk("mem_write_tied", 32'(mem_write), 32'(0));
        chk("byteenable_tied", 32'(mem_byteenable), 32'hF);

        // Basic: latency and steady-state throughput with ready held high.
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = '0; word_count = CNT_W'(4);
        model_push(0, 4);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        first_issue = -1;
        while (n < 20) begin
            @(negedge clk);
            if (mem_chipselect && first_issue < 0) first_issue = n;
            if (pix_valid) break;
            n++;
        end
        chk("first_issue_cycle", 32'(first_issue), 32'(1));
        chk("first_valid_cycle", 32'(n), 32'(3));
        wait_done(100, k);
        chk("done_cycle", 32'(n + k), 32'(11));
        repeat (4) @(posedge clk);

        // Address wrap at the top of memory.
        do_start(1022, 4, 1);
        wait_done(100, k);
        repeat (4) @(posedge clk);

        for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = $urandom;

        // Backpressure.
        rand_ready = 1'b1;
        do_start(int'($urandom_range(0, MEM_WORDS - 1)), 8, 1);
        wait_done(500, k);
        repeat (4) @(posedge clk);

        // Zero length.
        rand_ready = 1'b0;
        do_start(5, 0, 1);
        @(negedge clk);
        chk("zero_len_done", 32'(done), 32'(1));
        chk("zero_len_busy", 32'(busy), 32'(0));
        repeat (4) @(posedge clk);

        // Start while busy is ignored.
        rand_ready = 1'b1;
        b = int'($urandom_range(0, MEM_WORDS - 1));
        do_start(b, 3, 1);
        repeat (2) @(posedge clk);
        do_start(int'($urandom_range(0, MEM_WORDS - 1)), 5, 0);
        wait_done(500, k);
        repeat (6) @(posedge clk);

        // Reset mid-run, then a fresh transfer.
        rand_ready = 1'b0;
        do_start(b, 6, 1);
        p0 = popped_pix;
        k = 0;
        while ((popped_pix - p0) < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("three_pixels_before_reset", 32'((popped_pix - p0) >= 3), 32'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_addr.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midrun_reset");
        repeat (4) @(posedge clk);
        do_start(int'($urandom_range(0, MEM_WORDS - 1)), 3, 1);
        wait_done(200, k);
        repeat (4) @(posedge clk);

        // Half ordering of a recognisable word.
        mem_arr[100] = 32'hBBBB_AAAA;
        do_start(100, 1, 1);
        wait_done(100, k);
        repeat (4) @(posedge clk);

        // Random transfers.
        rand_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            do_start(int'($urandom_range(0, MEM_WORDS - 1)), int'($urandom_range(1, 12)), 1);
            wait_done(800, k);
            repeat (3) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
